// File: rtl/crc_16bit_chk_if.sv
`default_nettype none
// ============================================================================
//  Module   : crc_16bit_chk_if
//  Purpose  : Bundles the serial receive inputs and result outputs of the
//             CRC-16 packet checker.
//  Ports    : serial_in, shift_en, eop, clear  - driven by the bit source
//             busy, done, crc_ok, crc_err,
//             len_err, bit_cnt[13:0]           - driven by the checker
//  Modports : master = bit source / observer, slave = checker
//  Revision : 1.0 - initial release
// ============================================================================
interface crc_16bit_chk_if;
  logic        serial_in;
  logic        shift_en;
  logic        eop;
  logic        clear;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic        len_err;
  logic [13:0] bit_cnt;

  modport master (
    output serial_in, shift_en, eop, clear,
    input  busy, done, crc_ok, crc_err, len_err, bit_cnt
  );

  modport slave (
    input  serial_in, shift_en, eop, clear,
    output busy, done, crc_ok, crc_err, len_err, bit_cnt
  );
endinterface
`default_nettype wire

// File: rtl/crc_16bit_chk.sv
`default_nettype none
// ============================================================================
//  Module   : crc_16bit_chk
//  Purpose  : Serial CRC-16 (poly 0x8005, init 0) packet checker. Receives a
//             payload MSB-first followed by a 16-bit CRC field and reports
//             match / mismatch / length error one cycle after evaluation.
//  Ports    : clk     - rising-edge clock
//             n_rst   - asynchronous active-low reset
//             bus     - crc_16bit_chk_if.slave (serial inputs, result outputs)
//  Revision : 1.0 - initial release
// ============================================================================
module crc_16bit_chk (
  input  logic            clk,
  input  logic            n_rst,
  crc_16bit_chk_if.slave  bus
);

  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_RECV      = 2'd1;
  localparam logic [1:0]  S_EVAL      = 2'd2;

  localparam logic [15:0] C_POLY      = 16'h8005;
  localparam logic [13:0] C_CNT_MAX   = 14'h3FFF;
  // A packet needs at least the 16-bit CRC field; bits beyond that are payload.
  localparam logic [13:0] C_CRC_START = 14'd16;

  logic [1:0]  r_state;
  logic [15:0] r_crc;
  logic [15:0] r_hist;
  logic [13:0] r_cnt;
  logic        r_done;
  logic        r_ok;
  logic        r_crc_err;
  logic        r_len_err;

  logic        w_start;
  logic        w_accept;
  logic        w_load;
  logic [15:0] w_crc_base;
  logic [15:0] w_hist_base;
  logic [13:0] w_cnt_base;
  logic [15:0] w_crc_nxt;
  logic [15:0] w_hist_nxt;
  logic [13:0] w_cnt_nxt;
  logic        w_len_bad;
  logic        w_match;

  function automatic logic [15:0] crc_step(input logic [15:0] q, input logic b);
    logic t;
    t        = q[15] ^ b;
    crc_step = {q[14:0], 1'b0} ^ (t ? C_POLY : 16'h0000);
  endfunction

  // Datapath next-state. A new packet (any shift_en or eop seen in IDLE)
  // restarts from zero before its first bit is applied. The last 16 bits
  // sit in hist, so the CRC only ever sees bits that fall out of hist:
  // exactly the payload, never the received CRC field.
  always_comb begin
    w_start     = (r_state == S_IDLE) && (bus.shift_en || bus.eop);
    w_accept    = bus.shift_en && (r_state != S_EVAL);
    w_load      = w_start || w_accept;
    w_crc_base  = w_start ? 16'h0000 : r_crc;
    w_hist_base = w_start ? 16'h0000 : r_hist;
    w_cnt_base  = w_start ? 14'd0    : r_cnt;
    w_crc_nxt   = w_crc_base;
    w_hist_nxt  = w_hist_base;
    w_cnt_nxt   = w_cnt_base;
    if (w_accept) begin
      w_hist_nxt = {w_hist_base[14:0], bus.serial_in};
      if (w_cnt_base >= C_CRC_START) begin
        w_crc_nxt = crc_step(w_crc_base, w_hist_base[15]);
      end
      if (w_cnt_base != C_CNT_MAX) begin
        w_cnt_nxt = w_cnt_base + 14'd1;
      end
    end
  end

  // Saturated count is never a multiple of 8, but it is flagged explicitly
  // so the rule does not depend on that coincidence.
  assign w_len_bad = (r_cnt < C_CRC_START) || (r_cnt[2:0] != 3'd0) ||
                     (r_cnt == C_CNT_MAX);
  assign w_match   = (r_hist == ~r_crc);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_crc     <= 16'h0000;
      r_hist    <= 16'h0000;
      r_cnt     <= 14'd0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_crc_err <= 1'b0;
      r_len_err <= 1'b0;
    end else if (bus.clear) begin
      r_state   <= S_IDLE;
      r_crc     <= 16'h0000;
      r_hist    <= 16'h0000;
      r_cnt     <= 14'd0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_crc_err <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      // Result flags are qualified by done: they only live for one cycle.
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_crc_err <= 1'b0;
      r_len_err <= 1'b0;

      if (w_load) begin
        r_crc  <= w_crc_nxt;
        r_hist <= w_hist_nxt;
        r_cnt  <= w_cnt_nxt;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.eop) begin
            r_state <= S_EVAL;
          end else if (bus.shift_en) begin
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          if (bus.eop) begin
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b1;
          r_len_err <= w_len_bad;
          r_ok      <= !w_len_bad && w_match;
          r_crc_err <= !w_len_bad && !w_match;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (r_state == S_RECV) || (r_state == S_EVAL);
  assign bus.done    = r_done;
  assign bus.crc_ok  = r_ok;
  assign bus.crc_err = r_crc_err;
  assign bus.len_err = r_len_err;
  assign bus.bit_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_crc_16bit_chk.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_16bit_chk
//  Purpose  : Self-checking bench for crc_16bit_chk. Table of packets plus
//             hand-written sequences for clear, reset and back-to-back eop.
//             Expected results are queued when eop is driven and compared
//             when done appears (including done latency).
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crc_16bit_chk;

  localparam logic [2:0] F_OK  = 3'b100;
  localparam logic [2:0] F_CE  = 3'b010;
  localparam logic [2:0] F_LE  = 3'b001;
  localparam int         N_VEC = 11;

  typedef struct {
    logic [63:0] bits;
    int          nbits;
    bit          gap;
    logic [2:0]  flags;
    logic [13:0] cnt;
  } vec_t;

  typedef struct {
    logic [2:0]  flags;
    logic [13:0] cnt;
    bit          chk_cnt;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   edges = 0;

  exp_t sb_q[$];
  vec_t vecs[N_VEC];

  crc_16bit_chk_if bus ();

  crc_16bit_chk dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [63:0] payload, input int n);
    logic [15:0] q;
    logic        t;
    q = 16'h0000;
    for (int i = n - 1; i >= 0; i--) begin
      t = q[15] ^ payload[i];
      q = {q[14:0], 1'b0};
      if (t) q = q ^ 16'h8005;
    end
    return q;
  endfunction

  task automatic push_exp(input logic [2:0] flags, input logic [13:0] cnt, input bit chk_cnt);
    exp_t e;
    e.flags   = flags;
    e.cnt     = cnt;
    e.chk_cnt = chk_cnt;
    e.due     = edges + 2;
    sb_q.push_back(e);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the eop edge.
  task automatic send(input vec_t v);
    for (int i = v.nbits - 1; i >= 0; i--) begin
      if (v.gap) begin
        int g;
        g = $urandom_range(0, 3);
        bus.shift_en = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      bus.shift_en  = 1'b1;
      bus.serial_in = v.bits[i];
      bus.eop       = (i == 0);
      if (i == 0) push_exp(v.flags, v.cnt, 1'b1);
      @(posedge clk); #1;
      bus.shift_en = 1'b0;
      bus.eop      = 1'b0;
    end
  endtask

  task automatic shift_bits(input logic [15:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.shift_en  = 1'b1;
      bus.serial_in = b[i];
      @(posedge clk); #1;
    end
    bus.shift_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain_timeout", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},    bus.busy, 0);
    check({tag, "_done"},    bus.done, 0);
    check({tag, "_flags"},   {bus.crc_ok, bus.crc_err, bus.len_err}, 0);
    check({tag, "_bit_cnt"}, bus.bit_cnt, 0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("flags", {bus.crc_ok, bus.crc_err, bus.len_err}, e.flags);
        check("latency", edges, e.due);
        if (e.chk_cnt) check("bit_cnt", bus.bit_cnt, e.cnt);
      end
    end else begin
      check("flags_idle", {bus.crc_ok, bus.crc_err, bus.len_err}, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] fld;

    vecs[0]  = '{64'h0000_0000_0000_FFFF, 24, 1'b0, F_OK, 14'd24};
    vecs[1]  = '{64'h0000_0000_0080_7CFC, 24, 1'b0, F_OK, 14'd24};
    vecs[2]  = '{64'h0000_0000_0080_7CFD, 24, 1'b0, F_CE, 14'd24};
    vecs[3]  = '{64'h0000_0000_0000_0ABC, 12, 1'b0, F_LE, 14'd12};
    vecs[4]  = '{64'h0000_0000_0000_FFFF, 16, 1'b0, F_OK, 14'd16};
    vecs[5]  = '{64'h0000_0000_0000_0000, 16, 1'b0, F_CE, 14'd16};
    vecs[6]  = '{64'h0000_0000_0001_2345, 20, 1'b0, F_LE, 14'd20};
    vecs[7]  = '{64'h0000_0000_0080_7CFC, 24, 1'b1, F_OK, 14'd24};
    fld      = ~crc_model(64'h3132, 16);
    vecs[8]  = '{{32'h0, 16'h3132, fld},          32, 1'b0, F_OK, 14'd32};
    vecs[9]  = '{{32'h0, 16'h3132, fld ^ 16'h1},  32, 1'b1, F_CE, 14'd32};
    vecs[10] = '{64'h0000_0000_0000_00A5, 8, 1'b0, F_LE, 14'd8};

    n_rst         = 1'b0;
    bus.serial_in = 1'b0;
    bus.shift_en  = 1'b0;
    bus.eop       = 1'b0;
    bus.clear     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Table of packets
    for (int i = 0; i < N_VEC; i++) begin
      send(vecs[i]);
      drain();
    end

    // eop alone in IDLE: empty packet
    bus.eop = 1'b1;
    push_exp(F_LE, 14'd0, 1'b1);
    @(posedge clk); #1;
    bus.eop = 1'b0;
    drain();

    // New eop+bit presented in the cycle done is high: separate evaluation
    send(vecs[1]);
    @(posedge clk); #1;
    check("b2b_done_high", bus.done, 1);
    bus.shift_en  = 1'b1;
    bus.serial_in = 1'b1;
    bus.eop       = 1'b1;
    push_exp(F_LE, 14'd0, 1'b0);
    @(posedge clk); #1;
    bus.shift_en = 1'b0;
    bus.eop      = 1'b0;
    drain();

    // clear mid-packet, overriding simultaneous shift_en/eop
    shift_bits(16'h02AB, 10);
    check("pre_clear_busy", bus.busy, 1);
    bus.clear    = 1'b1;
    bus.shift_en = 1'b1;
    bus.eop      = 1'b1;
    @(posedge clk); #1;
    bus.clear    = 1'b0;
    bus.shift_en = 1'b0;
    bus.eop      = 1'b0;
    check("clear_busy", bus.busy, 0);
    check("clear_bit_cnt", bus.bit_cnt, 0);
    repeat (5) begin @(posedge clk); #1; end
    send(vecs[0]);
    drain();

    // Asynchronous reset mid-packet
    shift_bits(16'h0155, 10);
    #2;
    n_rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    @(posedge clk);
    @(posedge clk);
    #3;
    n_rst = 1'b1;
    @(posedge clk); #1;
    send(vecs[1]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crc_16bit_chk.md
CRC_16BIT_CHK -- requirements
Module: crc_16bit_chk

Interface
REQ-001: clk  input  1  system clock; all state updates on the rising edge.
REQ-002: n_rst  input  1  reset, asynchronous, active-low.
REQ-003: clear  input  1  synchronous abort/flush; highest priority after n_rst.
REQ-004: serial_in  input  1  received packet bit: payload MSB-first, then CRC field bit 15 first.
REQ-005: shift_en  input  1  serial_in valid this cycle; one bit accepted per high cycle.
REQ-006: eop  input  1  end-of-packet strobe; a bit with shift_en high in the same cycle is the last bit of the packet.
REQ-007: busy  output  1  high in RECV and EVAL states.
REQ-008: done  output  1  one-cycle pulse: result valid.
REQ-009: crc_ok  output  1  qualified by done: received CRC field matches.
REQ-010: crc_err  output  1  qualified by done: CRC mismatch on a well-formed packet.
REQ-011: len_err  output  1  qualified by done: bit count <16, not a multiple of 8, or counter saturated.
REQ-012: bit_cnt  output  14  bits accepted in the current/last packet, saturating at 16383.

Function
REQ-013: CRC arithmetic SHALL be: polynomial 0x8005, register init 0x0000, per-bit update t=Q[15]^bit, Q<=Q<<1, then Q^=0x8005 if t; expected field = ~Q.
REQ-014: Every accepted bit SHALL shift into the 16-bit delay line hist: hist<={hist[14:0],serial_in}.
REQ-015: Only bits leaving hist SHALL feed the CRC: once bit_cnt>=16 before the shift, hist[15] is the CRC update input, so the CRC covers exactly the payload.
REQ-016: FSM states: IDLE, RECV, EVAL.
REQ-017: IDLE->RECV on shift_en without eop; bit accepted, bit_cnt=1.
REQ-018: IDLE with eop (with or without shift_en) -> EVAL; the result is len_err.
REQ-019: RECV: accept bits on shift_en; eop -> EVAL after accepting any same-cycle bit.
REQ-020: EVAL lasts one cycle, shift_en ignored; outputs registered at the EVAL->IDLE edge; done high the cycle after EVAL (latency: done in the 2nd cycle after the eop edge).
REQ-021: Exactly one of crc_ok/crc_err/len_err SHALL be high with done; all three low when done is low.
REQ-022: len_err takes precedence over any CRC comparison.
REQ-023: crc_ok = (hist == ~Q) and no len_err; crc_err = mismatch and no len_err.
REQ-024: bit_cnt SHALL saturate at 16383; saturation forces len_err; CRC/hist continue shifting.
REQ-025: On the IDLE->RECV edge, Q and hist SHALL restart from zero (Q=0x0000) before the first bit is applied.
REQ-026: bit_cnt SHALL hold its final value until the next packet starts.
REQ-027: clear in any state: next state IDLE; Q, hist, bit_cnt and all outputs zeroed; no done pulse; clear overrides simultaneous shift_en/eop.
REQ-028: eop with shift_en in the same cycle that the FSM leaves EVAL (i.e. in IDLE) SHALL start a new evaluation; no packet is lost or merged.

Reset
REQ-029: While n_rst is low: state IDLE; Q=0x0000, hist=0x0000, bit_cnt=0; busy, done, crc_ok, crc_err, len_err all 0.
REQ-030: Reset asserted mid-packet SHALL abandon the packet without a done pulse; operation resumes from IDLE at the first edge after release.

Verification
REQ-031: Bits 00000000 then 16 ones, eop on the last bit -> done 2 cycles later, crc_ok=1, bit_cnt=24.
REQ-032: Payload 0x80 (MSB-first) then CRC field 0x7CFC -> crc_ok=1 (internal Q=0x8303); field 0x7CFD -> crc_err=1.
REQ-033: 12 bits then eop -> len_err=1, crc_ok=0, crc_err=0; eop alone in IDLE -> len_err=1, bit_cnt=0.
REQ-034: clear pulsed mid-packet after 10 bits -> busy drops the next cycle, no done; a following valid packet (REQ-031 stimulus) -> crc_ok.
REQ-035: n_rst low mid-packet -> all outputs 0 immediately (asynchronous); a subsequent packet checks correctly.
REQ-036: Gapped shift_en (random idle cycles) on the REQ-032 stimulus -> identical result to back-to-back bits.
